pc_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch: issues word-addressed fetch requests, holds the fetched instruction for decode, and computes the next PC.
- Next-PC sources: sequential, branch, jump, trap and trap return.
- Sits between the instruction memory port and the decode stage.
- Replaces a free-running PC register plus separate next-PC adders with one controlled sequencer.

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches instruction words, holds each for decode, then picks the
// next PC (trap, eret, jump, branch, sequential). Define PCSEQ_STALL_CNT_EN to add stall_cnt.
module pc_sequencer #(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(16),
    parameter int unsigned     MAX_WAIT  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            br_taken,
    input  logic [31:0]     br_offset,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            trap_req,
    input  logic            eret,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] epc,
    output logic            fetch_err
`ifdef PCSEQ_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    // Counter only needs to reach MAX_WAIT-1; the timeout fires on the edge ending that cycle.
    localparam int unsigned     CNT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

    state_e          state;
    logic [CNT_W-1:0] wait_cnt;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] next_pc;

    assign imem_addr = pc;
    assign pc_inc    = pc + PC_W'(1);
    assign br_off    = PC_W'($signed(br_offset));

    always_comb begin
        next_pc = pc_inc;
        if (trap_req) begin
            next_pc = TRAP_VEC;
        end else if (eret) begin
            next_pc = epc;
        end else if (jmp_valid) begin
            next_pc = jmp_target;
        end else if (br_taken) begin
            next_pc = pc_inc + br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StBoot;
            pc          <= RESET_VEC;
            epc         <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            fetch_err <= 1'b0;
            unique case (state)
                StBoot: begin
                    state    <= StFetch;
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                end
                StFetch: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= StHold;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Timeout: refetch from the trap vector with the request still up.
                        fetch_err <= 1'b1;
                        epc       <= pc;
                        pc        <= TRAP_VEC;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                StHold: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        pc          <= next_pc;
                        if (trap_req) begin
                            epc <= pc;
                        end
                        state <= StFetch;
                    end
                end
                default: begin
                    state    <= StBoot;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef PCSEQ_STALL_CNT_EN
    logic stall;

    assign stall = ((state == StFetch) && !imem_ack) ||
                   ((state == StHold) && instr_valid && !instr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: fetched words go into a scoreboard queue when acked
// and are compared when presented to decode; redirects are checked via imem_addr.
module tb_pc_sequencer;
    localparam int unsigned PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            br_taken;
    logic [31:0]     br_offset;
    logic            jmp_valid;
    logic [PC_W-1:0] jmp_target;
    logic            trap_req;
    logic            eret;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] epc;
    logic            fetch_err;
`ifdef PCSEQ_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .PC_W     (PC_W),
        .RESET_VEC(32'd0),
        .TRAP_VEC (32'd16),
        .MAX_WAIT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .trap_req   (trap_req),
        .eret       (eret),
        .pc         (pc),
        .epc        (epc),
        .fetch_err  (fetch_err)
`ifdef PCSEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 32'hxxxx_xxxx;
        return exp_q.pop_front();
    endfunction

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (imem_req === 1'b1);
    endtask

    // Leaves the bench at the negedge where the acked word should be held for decode.
    task automatic give_ack(input int delay, input logic [31:0] data);
        for (int d = 0; d < delay; d++) begin
            imem_ack = 1'b0;
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_q.push_back(data);
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    task automatic accept(input logic tr, input logic er, input logic jv,
                          input logic [PC_W-1:0] jt, input logic bt, input logic [31:0] bo);
        instr_ready = 1'b1;
        trap_req    = tr;
        eret        = er;
        jmp_valid   = jv;
        jmp_target  = jt;
        br_taken    = bt;
        br_offset   = bo;
        @(negedge clk);
        instr_ready = 1'b0;
        trap_req    = 1'b0;
        eret        = 1'b0;
        jmp_valid   = 1'b0;
        br_taken    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0; br_taken = 1'b0;
        br_offset = '0; jmp_valid = 1'b0; jmp_target = '0; trap_req = 1'b0; eret = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, instr_valid, fetch_err} !== 3'b000 || pc !== 0 || epc !== 0 ||
            instr !== 0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b err=%b pc=%h epc=%h instr=%h want all 0",
                     imem_req, instr_valid, fetch_err, pc, epc, instr);
        end
`ifdef PCSEQ_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL boot_first_req: req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(k) || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_req%0d: req=%b addr=%h valid=%b want 1 %h 0",
                         k, imem_req, imem_addr, instr_valid, k);
            end
            imem_ack   = 1'b1;
            imem_rdata = 32'(k);
            exp_q.push_back(32'(k));
            @(negedge clk);
            imem_ack = 1'b0;
            e = pop_exp();
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== e) begin
                errors++;
                $display("FAIL seq_hold%0d: valid=%b req=%b instr=%h want 1 0 %h",
                         k, instr_valid, imem_req, instr, e);
            end
            @(negedge clk);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_branch();
        bit ok;
        logic [31:0] e;
        give_ack(0, 32'h0000_0004);
        void'(pop_exp());
        accept(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'd5) begin
            errors++;
            $display("FAIL seq_to_5: addr=%h want 5", imem_addr);
        end
        give_ack(0, 32'hB0B0_0005);
        e = pop_exp();
        checks++;
        if (instr !== e) begin
            errors++;
            $display("FAIL instr_at_5: got %h want %h", instr, e);
        end
        accept(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'd2) begin
            errors++;
            $display("FAIL branch_back: addr=%h want 2", imem_addr);
        end
        give_ack(0, 32'h0000_0002);
        void'(pop_exp());
        accept(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'd3);
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'd6) begin
            errors++;
            $display("FAIL branch_fwd: addr=%h want 6", imem_addr);
        end
    endtask

    task automatic test_trap();
        bit ok;
        give_ack(0, 32'h0000_0006);
        void'(pop_exp());
        accept(1'b0, 1'b0, 1'b1, 32'd9, 1'b0, '0);
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'd9) begin
            errors++;
            $display("FAIL jump_to_9: addr=%h want 9", imem_addr);
        end
        give_ack(0, 32'h0000_0009);
        void'(pop_exp());
        accept(1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd5);
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'd16 || epc !== 32'd9) begin
            errors++;
            $display("FAIL trap_prio: addr=%h epc=%h want 10 9", imem_addr, epc);
        end
        give_ack(0, 32'h0000_0010);
        void'(pop_exp());
        accept(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'd9 || epc !== 32'd9) begin
            errors++;
            $display("FAIL eret: addr=%h epc=%h want 9 9", imem_addr, epc);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit early = 1'b0;
        logic [31:0] e;
        give_ack(0, 32'h0000_0009);
        void'(pop_exp());
        accept(1'b0, 1'b0, 1'b1, 32'd7, 1'b0, '0);
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'd7) begin
            errors++;
            $display("FAIL jump_to_7: addr=%h want 7", imem_addr);
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (fetch_err !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early || pc !== 32'd7) begin
            errors++;
            $display("FAIL timeout_early: early=%b pc=%h want 0 7", early, pc);
        end
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'd16 || epc !== 32'd7) begin
            errors++;
            $display("FAIL timeout: err=%b req=%b addr=%h epc=%h want 1 1 10 7",
                     fetch_err, imem_req, imem_addr, epc);
        end
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: err=%b req=%b want 0 1", fetch_err, imem_req);
        end
        give_ack(0, 32'h0000_0010);
        void'(pop_exp());
        accept(1'b0, 1'b0, 1'b1, 32'd7, 1'b0, '0);
        wait_req(ok);
        give_ack(14, 32'h0000_0077);
        e = pop_exp();
        checks++;
        if (!ok || fetch_err !== 1'b0 || instr_valid !== 1'b1 || pc !== 32'd7 || instr !== e) begin
            errors++;
            $display("FAIL ack_at_timeout: err=%b valid=%b pc=%h instr=%h want 0 1 7 %h",
                     fetch_err, instr_valid, pc, instr, e);
        end
    endtask

    task automatic test_hold_stall();
        bit ok;
        bit moved = 1'b0;
        logic [31:0] e;
`ifdef PCSEQ_STALL_CNT_EN
        logic [31:0] s0;
`endif
        accept(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        wait_req(ok);
        give_ack(0, 32'hDEAD_BEEF);
        e = pop_exp();
`ifdef PCSEQ_STALL_CNT_EN
        s0 = stall_cnt;
`endif
        for (int i = 0; i < 4; i++) begin
            br_taken  = i[0];
            br_offset = 32'd100;
            @(negedge clk);
            if (instr !== e || instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'd8)
                moved = 1'b1;
        end
        br_taken = 1'b0;
        checks++;
        if (!ok || moved) begin
            errors++;
            $display("FAIL hold_stable: instr=%h valid=%b pc=%h want %h 1 8",
                     instr, instr_valid, pc, e);
        end
`ifdef PCSEQ_STALL_CNT_EN
        checks++;
        if (stall_cnt - s0 !== 32'd4) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 4", stall_cnt - s0);
        end
`endif
        accept(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'd9) begin
            errors++;
            $display("FAIL after_hold: addr=%h want 9", imem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        logic [31:0] e;
        give_ack(0, 32'h0000_0009);
        void'(pop_exp());
        accept(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, '0);
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'h20) begin
            errors++;
            $display("FAIL jump_to_20: addr=%h want 20", imem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_req_drop: req=%b want 0", imem_req);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0BAD;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0 || epc !== 32'd0) begin
            errors++;
            $display("FAIL post_reset: req=%b addr=%h valid=%b epc=%h want 1 0 0 0",
                     imem_req, imem_addr, instr_valid, epc);
        end
        imem_ack = 1'b0;
        give_ack(0, 32'h0000_1234);
        e = pop_exp();
        checks++;
        if (instr !== e || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_fetch: instr=%h valid=%b want %h 1", instr, instr_valid, e);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_trap();
        test_timeout();
        test_hold_stall();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
